a2d_spi_master: RTL
===================

# a2d_spi_master

SPI master that runs a two-word conversion on the 12-bit A2D SPI slave. The first word selects the channel, and the second word returns the conversion result. It sits between the control logic and the A2D pins. It presents a single start/complete handshake and a 12-bit result, and it generates `SS_n`, `SCLK` and `MOSI` and samples `MISO`.

## Interface
- `SCLK_DIV`, default 32: `SCLK` period in `clk` cycles. Must be a power of 2 and at least 8. `HALF = SCLK_DIV/2`.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `strt_cnv`  in  1  start a conversion; sampled only in IDLE.
- `chnnl`  in  3  channel select; captured with `strt_cnv`.
- `MISO`  in  1  serial data from the slave.
- `SS_n`  out  1  active-low slave select; registered.
- `SCLK`  out  1  serial clock; idles high; registered.
- `MOSI`  out  1  serial data to the slave; equals `tx_shft[15]`.
- `res`  out  12  last conversion result; held between conversions.
- `cnv_cmplt`  out  1  set/reset flag; set when the result is valid.

## Operation
- Command word: `{2'b00, chnnl, 11'h000}`, sent in both transactions.
- Each transaction is 16 bits, MSB first.
- The slave drives its MSB when `SS_n` falls and shifts on `SCLK` falls.
- Master transmit side:
  - `tx_shft[15]` is valid while `SS_n` is low.
  - `tx_shft` shifts left on every `SCLK` fall except the first fall of each transaction, filling with 0.
- Master receive side: `rx_shft <= {rx_shft[14:0], MISO}` in the cycle `SCLK` rises.
- States:
  - IDLE: `strt_cnv` moves to TX1, captures `chnnl`, loads `tx_shft`, clears `cnv_cmplt`.
  - TX1: 16 `SCLK` cycles, then back porch, then GAP.
  - GAP: `SS_n` high for `SCLK_DIV` cycles; `tx_shft` reloads with the command word; then TX2.
  - TX2: identical to TX1, then DONE.
  - DONE: single cycle; `res <= rx_shft[11:0]`, set `cnv_cmplt`, return to IDLE.
- `strt_cnv` outside IDLE is ignored. There is no queuing and no abort.
- `strt_cnv` held high in IDLE starts a new conversion on every return to IDLE.
- `cnv_cmplt` stays high until the next accepted `strt_cnv`, which clears it in the same cycle. If set and clear coincide, set wins; this cannot occur from DONE.
- TX1 data received from the slave is discarded.
- `rst` at any time, including mid-transaction:
  - next cycle: state IDLE, `SS_n`=1, `SCLK`=1, `tx_shft`=0 (so `MOSI`=0), `rx_shft`=0, `res`=0, `cnv_cmplt`=0;
  - divider and bit counters are cleared;
  - the slave sees `SS_n` rise and terminates its own transaction.

## Timing
- Reset values: `SS_n`=1, `SCLK`=1, `MOSI`=0, `res`=12'h000, `cnv_cmplt`=0.
- Divider: `div_cnt` has `log2(SCLK_DIV)` bits.
  - Cleared on entry to TX1/TX2; free-runs while `SS_n` is low.
  - `SCLK` = 1 for `div_cnt` in [0, HALF−1] and 0 for [HALF, SCLK_DIV−1], registered.
  - Fall: the cycle `div_cnt` becomes HALF. Rise: the cycle `div_cnt` wraps to 0.
- Bit counter: 5 bits, counts rises; the transaction ends after rise 16.
  - After rise 16, `SCLK` is forced high for a HALF-cycle back porch; then `SS_n` rises.
  - `SS_n` low time per transaction: `T = 16*SCLK_DIV + HALF` cycles (528 at default).
- Schedule, with `strt_cnv` accepted at edge k:
  - `SS_n` falls at k+1;
  - `SS_n` rises at k+1+T;
  - `SS_n` falls again at k+1+T+SCLK_DIV;
  - `SS_n` rises, `res` updates and `cnv_cmplt` rises at k+1+2T+SCLK_DIV (k+1089 at default).
- Minimum `SCLK_DIV`=8 gives `SCLK` edges at least 4 cycles apart, leaving margin for the slave's 2-flop `SCLK` synchroniser.

## Test plan
- Reset: assert `rst` for 2 cycles -> `SS_n`=1, `SCLK`=1, `MOSI`=0, `res`=0, `cnv_cmplt`=0; all stay constant for 100 idle cycles.
- Channel 5, `SCLK_DIV`=32, bench SPI slave returning 16'h0ABC on the second word:
  - slave captures 16'h2800 on both words;
  - `res`=12'hABC and `cnv_cmplt`=1 exactly 1089 cycles after `strt_cnv`;
  - `SS_n` low windows are exactly 528 cycles with a 32-cycle gap.
- Edge count and spacing: count `SCLK` falls and rises per `SS_n` window -> exactly 16 of each; first fall 16 cycles after `SS_n` falls; `MOSI` never changes within 2 cycles of an `SCLK` rise.
- Busy and handshake:
  - pulse `strt_cnv` with `chnnl`=2 during TX1 of a `chnnl`=7 conversion -> ignored, command stays 16'h3800;
  - after completion, `cnv_cmplt` holds until the next `strt_cnv` and clears in that cycle.
- Reset mid-TX2, after bit 8 -> next cycle `SS_n`=1, `SCLK`=1, `res`=0; a new `strt_cnv` then completes normally with the correct result.
- Back-to-back conversions: `strt_cnv` held high, slave data 16'h0FFF then 16'h0001 -> `res`=12'hFFF then 12'h001. The second conversion starts the cycle after DONE, and `cnv_cmplt` drops in that cycle.

Source files
------------

// File: rtl/a2d_spi_master_if.sv
// Bus between the A2D SPI master, its control logic and the A2D pins.
interface a2d_spi_master_if;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        MISO;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic [11:0] res;
  logic        cnv_cmplt;

  modport master (
    input  strt_cnv, chnnl, MISO,
    output SS_n, SCLK, MOSI, res, cnv_cmplt
  );

  modport slave (
    output strt_cnv, chnnl, MISO,
    input  SS_n, SCLK, MOSI, res, cnv_cmplt
  );
endinterface

// File: rtl/a2d_spi_master.sv
// SPI master for a two-word A2D conversion: word 1 selects the channel,
// word 2 returns the 12-bit result. SCLK idles high, MSB first.
module a2d_spi_master #(
  parameter int unsigned SCLK_DIV = 32
) (
  input  logic              clk,
  input  logic              rst,
  a2d_spi_master_if.master  bus
);
  localparam int unsigned HALF = SCLK_DIV / 2;
  localparam int unsigned DW   = $clog2(SCLK_DIV);

  typedef enum logic [2:0] {IDLE, TX1, GAP, TX2, DONE} state_t;

  state_t          r_state;
  logic            r_ss_n;
  logic            r_sclk;
  logic [15:0]     r_tx_shft;
  // Only the low 12 received bits ever reach res, so only those are kept.
  logic [11:0]     r_rx_shft;
  logic [11:0]     r_res;
  logic            r_cnv_cmplt;
  logic [DW-1:0]   r_div_cnt;
  logic [4:0]      r_bit_cnt;
  logic [2:0]      r_chnnl;

  logic [DW-1:0]   w_div_nxt;
  logic            w_last_bit;
  logic            w_fall;
  logic            w_rise;
  logic [15:0]     w_cmd_new;
  logic [15:0]     w_cmd_held;

  // Divider look-ahead: SCLK edges are decoded from the next divider value.
  always_comb begin
    w_div_nxt  = r_div_cnt + 1'b1;
    w_last_bit = (r_bit_cnt == 5'd16);
    w_fall     = (w_div_nxt == DW'(HALF)) && !w_last_bit;
    w_rise     = (w_div_nxt == '0) && !w_last_bit;
    w_cmd_new  = {2'b00, bus.chnnl, 11'h000};
    w_cmd_held = {2'b00, r_chnnl, 11'h000};
  end

  // Conversion sequencer with registered SPI pins and result flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ss_n      <= 1'b1;
      r_sclk      <= 1'b1;
      r_tx_shft   <= '0;
      r_rx_shft   <= '0;
      r_res       <= '0;
      r_cnv_cmplt <= 1'b0;
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_chnnl     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ss_n <= 1'b1;
          r_sclk <= 1'b1;
          if (bus.strt_cnv) begin
            r_chnnl     <= bus.chnnl;
            r_tx_shft   <= w_cmd_new;
            r_cnv_cmplt <= 1'b0;
            r_state     <= TX1;
          end
        end
        TX1, TX2: begin
          // First cycle of a transaction only drops SS_n and clears counters.
          if (r_ss_n) begin
            r_ss_n    <= 1'b0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
          end else begin
            r_div_cnt <= w_div_nxt;
            r_sclk    <= ~w_div_nxt[DW-1] | w_last_bit;
            if (w_fall && (r_bit_cnt != 5'd0))
              r_tx_shft <= {r_tx_shft[14:0], 1'b0};
            if (w_rise) begin
              r_rx_shft <= {r_rx_shft[10:0], bus.MISO};
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
            // TX2 hands its final back-porch cycle to DONE so that SS_n rises
            // together with the result update, keeping both windows equal.
            if (w_last_bit && (r_state == TX2) && (r_div_cnt == DW'(HALF - 2)))
              r_state <= DONE;
            if (w_last_bit && (r_state == TX1) && (r_div_cnt == DW'(HALF - 1))) begin
              r_ss_n    <= 1'b1;
              r_sclk    <= 1'b1;
              r_div_cnt <= '0;
              r_state   <= GAP;
            end
          end
        end
        GAP: begin
          r_sclk <= 1'b1;
          if (r_div_cnt == DW'(SCLK_DIV - 2)) begin
            r_tx_shft <= w_cmd_held;
            r_state   <= TX2;
          end else begin
            r_div_cnt <= w_div_nxt;
          end
        end
        DONE: begin
          r_ss_n      <= 1'b1;
          r_sclk      <= 1'b1;
          r_res       <= r_rx_shft;
          r_cnv_cmplt <= 1'b1;
          r_div_cnt   <= '0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.SS_n      = r_ss_n;
  assign bus.SCLK      = r_sclk;
  assign bus.MOSI      = r_tx_shft[15];
  assign bus.res       = r_res;
  assign bus.cnv_cmplt = r_cnv_cmplt;
endmodule
